// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - RV32I decode types shared by the decode stage and its neighbours
package decode_stage_pkg;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [2:0] {
      alu_add = 3'd0, alu_sll = 3'd1, alu_sra = 3'd2, alu_sub = 3'd3,
      alu_xor = 3'd4, alu_srl = 3'd5, alu_or  = 3'd6, alu_and = 3'd7
   } alu_ops;

   typedef enum logic [2:0] {
      br_beq = 3'd0, br_bne = 3'd1, br_blt = 3'd4,
      br_bge = 3'd5, br_bltu = 3'd6, br_bgeu = 3'd7
   } branch_funct3_t;

   typedef enum logic [2:0] {
      f3_add = 3'd0, f3_sll = 3'd1, f3_slt = 3'd2, f3_sltu = 3'd3,
      f3_xor = 3'd4, f3_sr  = 3'd5, f3_or  = 3'd6, f3_and  = 3'd7
   } arith_funct3_t;

   typedef enum logic [2:0] {
      ld_lb = 3'd0, ld_lh = 3'd1, ld_lw = 3'd2, ld_lbu = 3'd4, ld_lhu = 3'd5
   } load_funct3_t;

   typedef enum logic [3:0] {
      rf_alu_out = 4'd0, rf_br_en = 4'd1, rf_u_imm = 4'd2, rf_lw  = 4'd3, rf_pc_plus4 = 4'd4,
      rf_lb      = 4'd5, rf_lbu   = 4'd6, rf_lh    = 4'd7, rf_lhu = 4'd8
   } regfilemux_sel_t;

   typedef enum logic { am1_rs1_out = 1'b0, am1_pc_out = 1'b1 } alumux1_sel_t;

   typedef enum logic [2:0] {
      am2_i_imm = 3'd0, am2_u_imm = 3'd1, am2_b_imm = 3'd2,
      am2_s_imm = 3'd3, am2_j_imm = 3'd4, am2_rs2_out = 3'd5
   } alumux2_sel_t;

   typedef enum logic { cm_rs2_out = 1'b0, cm_i_imm = 1'b1 } cmpmux_sel_t;

   typedef enum logic [1:0] {
      pcm_pc_plus4 = 2'd0, pcm_alu_out = 2'd1, pcm_alu_mod2 = 2'd2
   } pcmux_sel_t;

   localparam logic [6:0] muldiv_funct7 = 7'b0000001;

   typedef struct packed {
      rv32i_opcode     opcode;
      alu_ops          aluop;
      branch_funct3_t  cmpop;
      regfilemux_sel_t regfilemux;
      alumux1_sel_t    alumux1;
      alumux2_sel_t    alumux2;
      cmpmux_sel_t     cmpmux;
      pcmux_sel_t      pcmux;
      logic            load_regfile;
      logic            mem_read;
      logic            mem_write;
      logic            muldiv_en;
      logic [2:0]      muldiv_op;
   } rv32i_control_word;

   typedef struct packed {
      rv32i_control_word ctrl;
      logic [31:0]       pc;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [4:0]        rd;
      logic [31:0]       imm;
      logic              illegal;
   } decoded_instr_t;

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface decode_stage_if #(parameter int XLEN = 32);
   import decode_stage_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [XLEN-1:0]   in_pc;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   rv32i_control_word out_ctrl;
   logic [XLEN-1:0]   out_pc;
   logic [4:0]        out_rs1;
   logic [4:0]        out_rs2;
   logic [4:0]        out_rd;
   logic [XLEN-1:0]   out_imm;
   logic              out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_ctrl, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_ctrl, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_illegal
   );
endinterface

// File: rtl/decode_stage_logic.sv
// rtl/decode_stage_logic.sv - combinational RV32I(M) decoder: instruction word to decoded_instr_t
module decode_logic
   import decode_stage_pkg::*;
#(
   parameter bit ENABLE_M = 1'b0
) (
   input  logic [31:0]    instr_i,
   input  logic [31:0]    pc_i,
   output decoded_instr_t dec_o
);
   logic [6:0]  opc;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
   rv32i_control_word ctrl;
   logic [31:0] imm;
   logic        illegal;

   assign opc    = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];
   assign i_imm  = {{20{instr_i[31]}}, instr_i[31:20]};
   assign s_imm  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign b_imm  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
   assign u_imm  = {instr_i[31:12], 12'h000};
   assign j_imm  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

   always_comb begin
      ctrl            = '0;
      ctrl.opcode     = rv32i_opcode'(opc);
      ctrl.aluop      = alu_ops'(funct3);
      ctrl.cmpop      = branch_funct3_t'(funct3);
      ctrl.regfilemux = rf_alu_out;
      ctrl.alumux1    = am1_rs1_out;
      ctrl.alumux2    = am2_i_imm;
      ctrl.cmpmux     = cm_rs2_out;
      ctrl.pcmux      = pcm_pc_plus4;
      imm             = '0;
      illegal         = 1'b0;

      case (opc)
         op_lui: begin
            ctrl.load_regfile = 1'b1;
            ctrl.regfilemux   = rf_u_imm;
            imm               = u_imm;
         end
         op_auipc: begin
            ctrl.aluop        = alu_add;
            ctrl.alumux1      = am1_pc_out;
            ctrl.alumux2      = am2_u_imm;
            ctrl.load_regfile = 1'b1;
            imm               = u_imm;
         end
         op_jal: begin
            ctrl.aluop        = alu_add;
            ctrl.alumux1      = am1_pc_out;
            ctrl.alumux2      = am2_j_imm;
            ctrl.regfilemux   = rf_pc_plus4;
            ctrl.load_regfile = 1'b1;
            imm               = j_imm;
         end
         op_jalr: begin
            ctrl.aluop        = alu_add;
            ctrl.regfilemux   = rf_pc_plus4;
            ctrl.load_regfile = 1'b1;
            imm               = i_imm;
         end
         op_br: begin
            ctrl.aluop   = alu_add;
            ctrl.alumux1 = am1_pc_out;
            ctrl.alumux2 = am2_b_imm;
            imm          = b_imm;
         end
         op_load: begin
            ctrl.aluop        = alu_add;
            ctrl.mem_read     = 1'b1;
            ctrl.load_regfile = 1'b1;
            imm               = i_imm;
            case (funct3)
               ld_lb:   ctrl.regfilemux = rf_lb;
               ld_lh:   ctrl.regfilemux = rf_lh;
               ld_lw:   ctrl.regfilemux = rf_lw;
               ld_lbu:  ctrl.regfilemux = rf_lbu;
               ld_lhu:  ctrl.regfilemux = rf_lhu;
               default: illegal = 1'b1;
            endcase
         end
         op_store: begin
            ctrl.aluop     = alu_add;
            ctrl.alumux2   = am2_s_imm;
            ctrl.mem_write = 1'b1;
            imm            = s_imm;
            illegal        = (funct3 > 3'd2);
         end
         op_imm, op_reg: begin
            ctrl.load_regfile = 1'b1;
            if (opc == op_imm) begin
               imm = i_imm;
            end else begin
               ctrl.alumux2 = am2_rs2_out;
            end
            if (opc == op_reg && funct7 == muldiv_funct7) begin
               // M-extension results come back through the ALU writeback path
               if (ENABLE_M) begin
                  ctrl.muldiv_en = 1'b1;
                  ctrl.muldiv_op = funct3;
               end else begin
                  illegal = 1'b1;
               end
            end else begin
               case (funct3)
                  f3_slt, f3_sltu: begin
                     ctrl.cmpop      = (funct3 == f3_slt) ? br_blt : br_bltu;
                     ctrl.regfilemux = rf_br_en;
                     ctrl.cmpmux     = (opc == op_imm) ? cm_i_imm : cm_rs2_out;
                  end
                  f3_sr:   ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
                  f3_add:  if (opc == op_reg && funct7[5]) ctrl.aluop = alu_sub;
                  default: ;
               endcase
            end
         end
         default: illegal = 1'b1;
      endcase

      if (illegal) ctrl = '0;
   end

   always_comb begin
      dec_o         = '0;
      dec_o.ctrl    = ctrl;
      dec_o.pc      = pc_i;
      dec_o.rs1     = instr_i[19:15];
      dec_o.rs2     = instr_i[24:20];
      dec_o.rd      = instr_i[11:7];
      dec_o.imm     = imm;
      dec_o.illegal = illegal;
   end
endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage: decoder feeding a 2-entry skid FIFO
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   decode_stage_if.slave  bus
);
   decoded_instr_t dec;
   decoded_instr_t entry_q [2];
   decoded_instr_t head;
   logic           rd_ptr_q, rd_ptr_d;
   logic           wr_ptr_q, wr_ptr_d;
   logic [1:0]     count_q, count_d;
   logic           in_ready_q, in_ready_d;
   logic           push, pop, out_valid;

   decode_logic #(.ENABLE_M(ENABLE_M)) u_decode (
      .instr_i (bus.in_instr),
      .pc_i    (32'(bus.in_pc)),
      .dec_o   (dec)
   );

   assign out_valid = (count_q != 2'd0);
   assign push      = bus.in_valid && in_ready_q;
   assign pop       = out_valid && bus.out_ready;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      // flush wins over any push or pop in the same cycle
      if (bus.flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
      in_ready_d = (count_d != 2'd2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         in_ready_q <= 1'b1;
         entry_q[0] <= '0;
         entry_q[1] <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
         if (push && !bus.flush) entry_q[wr_ptr_q] <= dec;
      end
   end

   assign head            = entry_q[rd_ptr_q];
   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid;
   assign bus.out_ctrl    = head.ctrl;
   assign bus.out_pc      = XLEN'(head.pc);
   assign bus.out_rs1     = head.rs1;
   assign bus.out_rs2     = head.rs2;
   assign bus.out_rd      = head.rd;
   assign bus.out_imm     = XLEN'(signed'(head.imm));
   assign bus.out_illegal = head.illegal;
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the pipelined RV32I core. Accepts a fetched instruction and PC over a valid/ready handshake and decodes it into the shared `rv32i_control_word`, register indices and a format-selected immediate. Holds results in a 2-entry skid buffer so the stage sustains one instruction per cycle under downstream stalls. Supports optional M-extension decode, illegal-instruction flagging and pipeline flush.

## Interface
Parameters:
- `XLEN`, 32, width of PC and immediate datapath
- `ENABLE_M`, 0, 1 = decode RV32M multiply/divide; 0 = flag those encodings illegal

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `in_valid`  in  1  fetch offers an instruction
- `in_ready`  out  1  stage can accept; registered, no combinational path from `out_ready`
- `in_instr`  in  32  instruction word
- `in_pc`  in  XLEN  instruction address
- `flush`  in  1  discard all held and incoming instructions
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  execute consumes head entry
- `out_ctrl`  out  `rv32i_control_word`  decoded control
- `out_pc`  out  XLEN  PC of head entry
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices
- `out_imm`  out  XLEN  sign-extended immediate for the instruction's format
- `out_illegal`  out  1  head entry is an unknown or disabled encoding

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Decode is combinational on `in_instr`, written into the buffer at transfer in.
- Defaults: `aluop = funct3`, `regfilemux = alu_out`, `alumux1 = rs1_out`, `alumux2 = i_imm`, `cmpop = funct3`, `cmpmux = rs2_out`, `pcmux = pc_plus4`; all loads/enables 0; `opcode` copied.
- lui: load rd from `u_imm`. auipc: pc + u_imm to rd. jal: alu pc + j_imm, rd ← pc_plus4. jalr: rs1 + i_imm, rd ← pc_plus4. br: alu pc + b_imm, no rd write.
- load: `mem_read=1`, rs1 + i_imm, regfilemux by funct3 (lb/lh/lw/lbu/lhu); funct3 3,6,7 → illegal.
- store: `mem_write=1`, rs1 + s_imm; funct3 > 2 → illegal.
- op_imm/op_reg: slt/sltu write `br_en`, cmpop blt/bltu, cmpmux i_imm/rs2_out. sr selects sra when `funct7[5]`, else srl. op_reg add selects sub when `funct7[5]`. Others: aluop = funct3, regfilemux alu_out.
- op_reg with `funct7 == 7'b0000001`: `ENABLE_M=1` → `muldiv_en=1`, `muldiv_op=funct3`, rd ← alu_out; `ENABLE_M=0` → illegal.
- Immediate: I (load, jalr, op_imm), S (store), B (br), U (lui, auipc), J (jal); 0 otherwise.
- Illegal/unknown opcode: `ctrl` all zero, `out_illegal=1`, entry still delivered in order.

## Timing
- Reset: buffer empty, `out_valid=0`, `in_ready=1`, `out_ctrl=0`, `out_pc=0`, `out_imm=0`, indices 0, `out_illegal=0`.
- Latency: 1 cycle from transfer in to `out_valid`. Throughput: 1/cycle while `out_ready=1`.
- Buffer: FIFO, count 0–2. `in_ready = (count < 2)`, registered. Push and pop in the same cycle leave count unchanged. Order is preserved.
- Outputs stable while `out_valid && !out_ready`.
- `flush`: count → 0 next cycle; an input transferred in the flush cycle is dropped; `out_valid=0` next cycle. Flush has priority over push/pop.
- Reset mid-operation: immediate empty, no partial entry survives.

## Structure
- Add to `rv32i_types`: `muldiv_en` and `muldiv_op[2:0]` fields in `rv32i_control_word`, `muldiv_funct7` constant, and a `decoded_instr_t` struct (ctrl, pc, rs1, rs2, rd, imm, illegal).
- One sub-module: `decode_logic`, purely combinational (instr → `decoded_instr_t`). The sequential skid buffer lives in `decode_stage`.

## Test plan
- `0x00500093` (addi x1,x0,5) → next cycle `out_valid=1`, aluop add, load_regfile 1, alumux2 i_imm, rd 1, imm 5.
- `0x402081B3` (sub x3,x1,x2) → aluop sub, alumux2 rs2_out; `0x4020D093` (srai x1,x1,2) → aluop sra, imm 0x402.
- `0x022081B3` (mul): `ENABLE_M=1` → muldiv_en 1, muldiv_op 0; `ENABLE_M=0` → illegal 1, ctrl 0. `0xFFFFFFFF` → illegal 1.
- `out_ready=0` for 4 cycles, 3 instructions offered back-to-back → 2 accepted, `in_ready=0` from cycle 3, then drained in order with the third following.
- Full buffer plus simultaneous push and `flush` → `out_valid=0` next cycle, nothing from before or during the flush emerges.
- Assert `rst` with 2 entries held → outputs return to reset values immediately, `in_ready=1`.
